inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the fetch stage (IFU) and decode (IDU).
- Absorbs fetched {pc, inst, fetch exception} packets when IDU stalls, so the IFU/icache can keep streaming.
- Uses the same valid/allowin handshake on both sides.
- Discards all contents on pipeline flush (flush_sign) or branch redirect (br_flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_to_ifq_valid  in  1  IFU packet valid (IFU's ifu_to_idu_valid).
- ifq_allowin  out  1  queue can accept a packet (drives IFU's idu_allowin).
- pc_i  in  32  fetched PC.
- inst_i  in  32  fetched instruction word.
- excp_i  in  1  fetch-side exception flag.
- excp_num_i  in  16  one-hot fetch exception vector (ADEF/TLBR/PIF/PPI bits).
- ifq_to_idu_valid  out  1  head entry valid for IDU.
- idu_allowin  in  1  IDU accepts this cycle.
- pc_o  out  32  head PC.
- inst_o  out  32  head instruction.
- excp_o  out  1  head exception flag.
- excp_num_o  out  16  head exception vector.
- flush_sign  in  1  exception/ertn flush.
- br_flush  in  1  branch-mispredict redirect.
- ifq_count  out  PTR_W+1  current occupancy (debug/perf).

Behaviour:
- Reset (rst_n low, async): wptr=0, rptr=0, count=0, all storage entries cleared to zero. Outputs during and after reset: ifq_to_idu_valid=0, ifq_allowin=1, pc_o=0, inst_o=0, excp_o=0, excp_num_o=0, ifq_count=0. Deassertion takes effect at the next edge.
- flush = flush_sign | br_flush.
- Input side:
  - ifq_allowin = (count != DEPTH). It depends only on registered state, never on idu_allowin; this is deliberate, to cut the IDU->IFU->icache combinational path.
  - push = ifu_to_ifq_valid & ifq_allowin & ~flush.
  - On push, the entry {pc_i, inst_i, excp_i, excp_num_i} is written at wptr and wptr increments.
- Output side:
  - ifq_to_idu_valid = (count != 0) & ~flush.
  - Data outputs always show the entry at rptr, as a combinational read of registered storage.
  - pop = ifq_to_idu_valid & idu_allowin; rptr increments on pop.
- Latency: a packet pushed at edge N is presented to IDU in cycle N+1 at the earliest. There is no same-cycle bypass.
- Occupancy update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - push & pop: unchanged, both pointers advance.
- Pointers wrap modulo DEPTH (natural PTR_W overflow).
- Full (count==DEPTH): ifq_allowin=0 even if IDU pops the same cycle. The slot becomes visible next cycle.
- Empty (count==0): ifq_to_idu_valid=0. A push in the same cycle does not pass through.
- Flush cycle:
  - Push and pop are both suppressed.
  - At the next edge: wptr=rptr=0, count=0.
  - Storage contents are not cleared; they are unreachable.
  - ifq_allowin stays at its pre-flush value during the flush cycle. Any IFU handshake in that cycle is dropped by design; IFU also cancels its own state on flush.
- Back-to-back flushes keep the queue empty. The first push after flush deassertion is accepted normally.
- Excp entries travel like any other; the queue never inspects excp_num.
- Invariant: 0 <= count <= DEPTH at all times. Bench assertions are required for no push when full and no pop when empty.

Decomposition:
- Shared package (ifq_pkg): PC_W=32, INST_W=32, EXCP_NUM_W=16, IFQ_ENTRY_W=PC_W+INST_W+1+EXCP_NUM_W; entry field offsets (pack/unpack helpers).
- One sub-module, ifq_storage:
  - DEPTH x IFQ_ENTRY_W register array.
  - Sync write port (we, waddr, wdata), async read port (raddr, rdata).
  - Async active-low reset clears the array.
- Pointer/count/handshake logic stays in inst_fetch_queue.

Test Plan:
- Reset: hold rst_n=0 mid-traffic -> immediately ifq_to_idu_valid=0, ifq_allowin=1, ifq_count=0, pc_o=0; after release, push pc=0x1c000000 -> visible next cycle with ifq_count=1.
- Fill/backpressure (DEPTH=4, idu_allowin=0): push pcs 0x1c000000..0x1c00000c -> ifq_count=4, ifq_allowin=0. A fifth valid with pc 0x1c000010 is not accepted. Raise idu_allowin -> pops in order 0x...00, 04, 08, 0c.
- Streaming: valid and idu_allowin both held 1 for 20 cycles, pcs incrementing by 4 -> after the first cycle IDU receives one packet per cycle in order, count stays 1, pointers wrap past DEPTH with no loss or duplication.
- Full + simultaneous pop: count=4, idu_allowin=1, IFU valid=1 -> that cycle ifq_allowin=0 and the pop occurs. Next cycle count=3, ifq_allowin=1 and the pending packet is accepted.
- Flush: count=3, assert br_flush for one cycle with IFU valid=1 (pc 0x1c000100) -> ifq_to_idu_valid=0 that cycle, no pop, packet 0x1c000100 dropped. Next cycle count=0. Then push 0x1c000200 -> first IDU packet is 0x1c000200. Repeat using flush_sign.
- Exception carry: push excp_i=1, excp_num_i=16'h0004, inst_i=0 -> IDU sees excp_o=1, excp_num_o=16'h0004, unchanged relative to surrounding normal entries.

Source files
------------

// File: rtl/ifq_pkg.sv
// ---------------------------------------------------------------------------
// ifq_pkg
// Shared definitions for the instruction fetch queue: field widths, the
// fetch-packet entry layout and pack/unpack helpers used by the queue top and
// its storage array.
// ---------------------------------------------------------------------------
package ifq_pkg;

   localparam int PC_W        = 32;
   localparam int INST_W      = 32;
   localparam int EXCP_NUM_W  = 16;
   localparam int IFQ_ENTRY_W = PC_W + INST_W + 1 + EXCP_NUM_W;

   // Field offsets inside a packed entry word, LSB first.
   localparam int EXCP_NUM_LSB = 0;
   localparam int EXCP_LSB     = EXCP_NUM_LSB + EXCP_NUM_W;
   localparam int INST_LSB     = EXCP_LSB + 1;
   localparam int PC_LSB       = INST_LSB + INST_W;

   typedef logic [IFQ_ENTRY_W-1:0] ifq_word_t;

   typedef struct packed {
      logic [PC_W-1:0]       pc;
      logic [INST_W-1:0]     inst;
      logic                  excp;
      logic [EXCP_NUM_W-1:0] excp_num;
   } ifq_entry_t;

   function automatic ifq_word_t pack_entry(input ifq_entry_t e);
      ifq_word_t w;
      w = '0;
      w[PC_LSB       +: PC_W]       = e.pc;
      w[INST_LSB     +: INST_W]     = e.inst;
      w[EXCP_LSB]                   = e.excp;
      w[EXCP_NUM_LSB +: EXCP_NUM_W] = e.excp_num;
      return w;
   endfunction

   function automatic ifq_entry_t unpack_entry(input ifq_word_t w);
      ifq_entry_t e;
      e.pc       = w[PC_LSB       +: PC_W];
      e.inst     = w[INST_LSB     +: INST_W];
      e.excp     = w[EXCP_LSB];
      e.excp_num = w[EXCP_NUM_LSB +: EXCP_NUM_W];
      return e;
   endfunction

endpackage : ifq_pkg

// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if
// Handshake and payload bundle between IFU, the fetch queue and IDU.
//   IFU side : ifu_to_ifq_valid, ifq_allowin, pc_i, inst_i, excp_i, excp_num_i
//   IDU side : ifq_to_idu_valid, idu_allowin, pc_o, inst_o, excp_o, excp_num_o
// Modports:
//   slave  - the queue itself (consumes IFU packets, produces IDU packets)
//   master - the surrounding pipeline (drives IFU packets, consumes IDU side)
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if;
   import ifq_pkg::*;

   logic                  ifu_to_ifq_valid;
   logic                  ifq_allowin;
   logic [PC_W-1:0]       pc_i;
   logic [INST_W-1:0]     inst_i;
   logic                  excp_i;
   logic [EXCP_NUM_W-1:0] excp_num_i;

   logic                  ifq_to_idu_valid;
   logic                  idu_allowin;
   logic [PC_W-1:0]       pc_o;
   logic [INST_W-1:0]     inst_o;
   logic                  excp_o;
   logic [EXCP_NUM_W-1:0] excp_num_o;

   modport slave (
      input  ifu_to_ifq_valid, pc_i, inst_i, excp_i, excp_num_i, idu_allowin,
      output ifq_allowin, ifq_to_idu_valid, pc_o, inst_o, excp_o, excp_num_o
   );

   modport master (
      output ifu_to_ifq_valid, pc_i, inst_i, excp_i, excp_num_i, idu_allowin,
      input  ifq_allowin, ifq_to_idu_valid, pc_o, inst_o, excp_o, excp_num_o
   );

endinterface : inst_fetch_queue_if

// File: rtl/ifq_storage.sv
// ---------------------------------------------------------------------------
// ifq_storage
// DEPTH x IFQ_ENTRY_W register array for the fetch queue.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset (clears array)
//   we_i, waddr_i,
//   wdata_i            - synchronous write port
//   raddr_i, rdata_o   - asynchronous (combinational) read port
// ---------------------------------------------------------------------------
module ifq_storage
   import ifq_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  ifq_word_t        wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output ifq_word_t        rdata_o
);

   ifq_word_t mem_q [DEPTH];

   // NOTE: the array is reset on purpose so the head outputs read as zero out
   // of reset; this keeps it as flops rather than an inferred RAM macro.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ifq_storage

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
// Decoupling FIFO between fetch (IFU) and decode (IDU). Buffers
// {pc, inst, excp, excp_num} packets while IDU stalls and discards all
// contents on flush_sign or br_flush.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - inst_fetch_queue_if.slave: IFU push side and IDU pop side
//   flush_sign   - exception/ertn flush
//   br_flush     - branch-mispredict redirect
//   ifq_count    - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_fetch_queue
   import ifq_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   inst_fetch_queue_if.slave  bus,
   input  logic               flush_sign,
   input  logic               br_flush,
   output logic [PTR_W:0]     ifq_count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic       flush;
   logic       push;
   logic       pop;
   ifq_word_t  wdata;
   ifq_word_t  rdata;
   ifq_entry_t head;

   assign flush = flush_sign | br_flush;

   // allowin looks only at registered occupancy, so a full queue refuses a
   // packet even when IDU pops in the same cycle. This keeps idu_allowin out
   // of the IFU/icache timing path.
   assign bus.ifq_allowin      = (count_q != FULL_CNT);
   assign bus.ifq_to_idu_valid = (count_q != '0) & ~flush;

   assign push = bus.ifu_to_ifq_valid & bus.ifq_allowin & ~flush;
   assign pop  = bus.ifq_to_idu_valid & bus.idu_allowin;

   // NOTE: every next-state signal gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         // Storage is left untouched; resetting the pointers makes it
         // unreachable.
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign wdata = pack_entry('{pc:       bus.pc_i,
                               inst:     bus.inst_i,
                               excp:     bus.excp_i,
                               excp_num: bus.excp_num_i});

   ifq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wdata),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   // Head data is a plain read of storage; there is no bypass from the input.
   assign head           = unpack_entry(rdata);
   assign bus.pc_o       = head.pc;
   assign bus.inst_o     = head.inst;
   assign bus.excp_o     = head.excp;
   assign bus.excp_num_o = head.excp_num;

   assign ifq_count = count_q;

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed self-checking bench for inst_fetch_queue (DEPTH=4).
// Inputs change 1ns after a rising edge; outputs are checked 1ns later.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;
   import ifq_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       flush_sign;
   logic       br_flush;
   logic [2:0] ifq_count;

   int n_pass  = 0;
   int n_total = 0;

   inst_fetch_queue_if bus ();

   inst_fetch_queue #(
      .DEPTH (4)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .flush_sign (flush_sign),
      .br_flush   (br_flush),
      .ifq_count  (ifq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h0bad_f00d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic e, input logic [15:0] n);
      bus.ifu_to_ifq_valid = v;
      bus.pc_i             = pc;
      bus.inst_i           = inst;
      bus.excp_i           = e;
      bus.excp_num_i       = n;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 16'h0);
   endtask

   task automatic push_pkt(input logic [31:0] pc);
      drive(1'b1, pc, inst_of(pc), 1'b0, 16'h0);
      tick();
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      #1;
      check({tag, "_valid"}, bus.ifq_to_idu_valid, 1'b1);
      check({tag, "_pc"},    bus.pc_o,             pc);
      check({tag, "_inst"},  bus.inst_o,           inst_of(pc));
   endtask

   // Occupancy invariants: never offer a slot when full, never present a
   // packet when empty, never exceed DEPTH.
   always @(negedge clk) begin
      check("no_push_full", bus.ifq_allowin      & (ifq_count == 3'd4), 1'b0);
      check("no_pop_empty", bus.ifq_to_idu_valid & (ifq_count == 3'd0), 1'b0);
      check("count_range",  ifq_count > 3'd4,                           1'b0);
   end

   initial begin
      rst_n           = 1'b0;
      flush_sign      = 1'b0;
      br_flush        = 1'b0;
      bus.idu_allowin = 1'b0;
      drive(1'b1, 32'h1c00_0000, 32'h1, 1'b0, 16'h0);
      tick();
      tick();

      // ---------------- reset ----------------
      #1;
      check("rst_valid",   bus.ifq_to_idu_valid, 1'b0);
      check("rst_allowin", bus.ifq_allowin,      1'b1);
      check("rst_count",   ifq_count,            3'd0);
      check("rst_pc",      bus.pc_o,             32'h0);
      check("rst_inst",    bus.inst_o,           32'h0);
      check("rst_excpnum", bus.excp_num_i == 16'h0 ? bus.excp_num_o : 16'hffff, 16'h0);

      rst_n = 1'b1;
      drive(1'b1, 32'h1c00_0000, inst_of(32'h1c00_0000), 1'b0, 16'h0);
      #1;
      check("empty_no_bypass", bus.ifq_to_idu_valid, 1'b0);
      tick();
      check("first_count", ifq_count, 3'd1);
      drive(1'b1, 32'h1c00_0004, inst_of(32'h1c00_0004), 1'b0, 16'h0);
      check_head("first", 32'h1c00_0000);
      tick();
      check("pre_rst_count", ifq_count, 3'd2);

      // Async reset mid-traffic: outputs clear without waiting for an edge.
      rst_n = 1'b0;
      #1;
      check("async_valid",   bus.ifq_to_idu_valid, 1'b0);
      check("async_allowin", bus.ifq_allowin,      1'b1);
      check("async_count",   ifq_count,            3'd0);
      check("async_pc",      bus.pc_o,             32'h0);
      tick();
      rst_n = 1'b1;
      idle();
      tick();

      // ---------------- fill / backpressure ----------------
      bus.idu_allowin = 1'b0;
      for (int i = 0; i < 4; i++) push_pkt(32'h1c00_0000 + 32'(4 * i));
      drive(1'b1, 32'h1c00_0010, inst_of(32'h1c00_0010), 1'b0, 16'h0);
      #1;
      check("full_count",   ifq_count,       3'd4);
      check("full_allowin", bus.ifq_allowin, 1'b0);
      tick();
      check("fifth_dropped", ifq_count, 3'd4);
      idle();
      bus.idu_allowin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_head("drain", 32'h1c00_0000 + 32'(4 * i));
         tick();
      end
      check("drain_count", ifq_count,            3'd0);
      check("drain_valid", bus.ifq_to_idu_valid, 1'b0);

      // ---------------- streaming ----------------
      bus.idu_allowin = 1'b1;
      drive(1'b1, 32'h1c00_1000, inst_of(32'h1c00_1000), 1'b0, 16'h0);
      #1;
      check("stream_start_valid", bus.ifq_to_idu_valid, 1'b0);
      tick();
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 32'h1c00_1000 + 32'(4 * k), inst_of(32'h1c00_1000 + 32'(4 * k)),
               1'b0, 16'h0);
         check_head("stream", 32'h1c00_1000 + 32'(4 * (k - 1)));
         check("stream_count", ifq_count, 3'd1);
         tick();
      end
      idle();
      check_head("stream_last", 32'h1c00_1050);
      tick();
      check("stream_end_count", ifq_count, 3'd0);

      // ---------------- full + simultaneous pop ----------------
      bus.idu_allowin = 1'b0;
      for (int i = 0; i < 4; i++) push_pkt(32'h1c00_2000 + 32'(4 * i));
      bus.idu_allowin = 1'b1;
      drive(1'b1, 32'h1c00_2010, inst_of(32'h1c00_2010), 1'b0, 16'h0);
      #1;
      check("fp_allowin", bus.ifq_allowin, 1'b0);
      check_head("fp_pop", 32'h1c00_2000);
      tick();
      check("fp_count3",   ifq_count,       3'd3);
      check("fp_allowin1", bus.ifq_allowin, 1'b1);
      check_head("fp_next", 32'h1c00_2004);
      tick();
      check("fp_accept_count", ifq_count, 3'd3);
      idle();
      bus.idu_allowin = 1'b0;
      check_head("fp_after", 32'h1c00_2008);

      // ---------------- br_flush with count=3 ----------------
      br_flush        = 1'b1;
      bus.idu_allowin = 1'b1;
      drive(1'b1, 32'h1c00_0100, inst_of(32'h1c00_0100), 1'b0, 16'h0);
      #1;
      check("brf_valid",   bus.ifq_to_idu_valid, 1'b0);
      check("brf_allowin", bus.ifq_allowin,      1'b1);
      tick();
      br_flush = 1'b0;
      idle();
      bus.idu_allowin = 1'b0;
      check("brf_count", ifq_count, 3'd0);
      push_pkt(32'h1c00_0200);
      idle();
      check("brf_push_count", ifq_count, 3'd1);
      check_head("brf_first", 32'h1c00_0200);
      bus.idu_allowin = 1'b1;
      tick();
      check("brf_pop_count", ifq_count, 3'd0);

      // ---------------- flush_sign, back-to-back ----------------
      bus.idu_allowin = 1'b0;
      for (int i = 0; i < 3; i++) push_pkt(32'h1c00_0300 + 32'(4 * i));
      check("fs_pre_count", ifq_count, 3'd3);
      flush_sign      = 1'b1;
      bus.idu_allowin = 1'b1;
      drive(1'b1, 32'h1c00_0104, inst_of(32'h1c00_0104), 1'b0, 16'h0);
      #1;
      check("fs_valid", bus.ifq_to_idu_valid, 1'b0);
      tick();
      check("fs_count", ifq_count, 3'd0);
      tick();
      check("fs_b2b_count", ifq_count, 3'd0);
      flush_sign      = 1'b0;
      bus.idu_allowin = 1'b0;
      push_pkt(32'h1c00_0400);
      idle();
      check("fs_push_count", ifq_count, 3'd1);
      check_head("fs_first", 32'h1c00_0400);
      bus.idu_allowin = 1'b1;
      tick();

      // ---------------- exception carry ----------------
      bus.idu_allowin = 1'b0;
      push_pkt(32'h1c00_0500);
      drive(1'b1, 32'h1c00_0504, 32'h0, 1'b1, 16'h0004);
      tick();
      push_pkt(32'h1c00_0508);
      idle();
      bus.idu_allowin = 1'b1;
      check_head("ex_a", 32'h1c00_0500);
      check("ex_a_excp", bus.excp_o,     1'b0);
      check("ex_a_num",  bus.excp_num_o, 16'h0);
      tick();
      check("ex_b_pc",   bus.pc_o,       32'h1c00_0504);
      check("ex_b_inst", bus.inst_o,     32'h0);
      check("ex_b_excp", bus.excp_o,     1'b1);
      check("ex_b_num",  bus.excp_num_o, 16'h0004);
      tick();
      check_head("ex_c", 32'h1c00_0508);
      check("ex_c_excp", bus.excp_o,     1'b0);
      check("ex_c_num",  bus.excp_num_o, 16'h0);
      tick();
      check("ex_end_count", ifq_count, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_inst_fetch_queue
